// File: rtl/uart_rx.sv
// Purpose:      8N1 UART receiver that samples each bit at its mid-point, LSB first.
// Latency:      rx_valid/frame_err rise 1 clk after the stop-bit sample (~2 + HALF_BIT + 9*CLKS_PER_BIT clk from the start edge).
// Backpressure: none. rx_data holds until the next good frame, and an unread byte is overwritten.
//
// Ports:
//   clk        system clock, posedge
//   rst        asynchronous active-high reset
//   rxd        serial input, asynchronous to clk, idle high
//   rx_data    last correctly framed byte (bit 0 = first data bit on the line)
//   rx_valid   one-cycle strobe; rx_data is new in the same cycle
//   frame_err  one-cycle strobe when the stop bit samples low
//   busy       high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  data_nxt;
  logic        vld_nxt, ferr_nxt;

  // Two-flop synchroniser plus one delay flop for edge detection. The flops
  // reset high so that a line that is low out of reset is not taken as an edge.
  logic rxd_m, rxd_s, rxd_s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m   <= 1'b1;
      rxd_s   <= 1'b1;
      rxd_s_d <= 1'b1;
    end else begin
      rxd_m   <= rxd;
      rxd_s   <= rxd_m;
      rxd_s_d <= rxd_s;
    end
  end

  // Only a genuine high-to-low transition starts a frame. A stuck-low line,
  // including one that stays low after a framing error, never re-triggers.
  logic start_edge;
  assign start_edge = rxd_s_d & ~rxd_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      rx_data   <= data_nxt;
      rx_valid  <= vld_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    data_nxt    = rx_data;
    vld_nxt     = 1'b0;
    ferr_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = START;
          cnt_nxt   = 16'd0;
        end
      end

      // Half a bit into the start bit. If the line is still low, the start
      // bit is real. If it is high, it was a glitch and is dropped silently.
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt = 16'd0;
          if (!rxd_s) begin
            state_nxt   = DATA;
            bit_idx_nxt = 3'd0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      // Each counter wrap is one full bit later, which lands at mid-bit.
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt     = 16'd0;
          shift_nxt   = {rxd_s, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      // Returning to IDLE at mid-stop leaves half a bit of slack before a
      // back-to-back start bit can arrive.
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nxt   = 16'd0;
          state_nxt = IDLE;
          if (rxd_s) begin
            data_nxt = shift;
            vld_nxt  = 1'b1;
          end else begin
            ferr_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Purpose:      directed self-checking bench for uart_rx at 16 clk/bit.
// Latency:      frames are checked a fixed idle gap after their stop bit ends.
// Backpressure: none; a negedge monitor records every strobe the DUT emits.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_rx #(.CLKS_PER_BIT(16), .HALF_BIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: record strobes and pulse-shape violations away from the active edge.
  int         cyc = 0;
  logic [7:0] vld_dat[$];
  int         vld_cyc[$];
  logic [7:0] last_dat = 8'h00;
  int         ferr_cnt = 0;
  bit         both_high = 0;
  bit         long_pulse = 0;
  logic       prev_vld = 1'b0;
  logic       prev_ferr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      vld_dat.push_back(rx_data);
      vld_cyc.push_back(cyc);
      last_dat = rx_data;
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (rx_valid === 1'b1 && frame_err === 1'b1) both_high = 1;
    if ((rx_valid === 1'b1 && prev_vld === 1'b1) ||
        (frame_err === 1'b1 && prev_ferr === 1'b1)) long_pulse = 1;
    prev_vld  = rx_valid;
    prev_ferr = frame_err;
  end

  // Every wait ends 1 time unit after a posedge, so stimulus changes away from the edge.
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int n);
    rxd = b;
    wait_clks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int n);
    send_bit(1'b0, n);
    for (int i = 0; i < 8; i++) send_bit(d[i], n);
    send_bit(stop_b, n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rxd = 1'b1;
    wait_clks(5);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    wait_clks(10);
  endtask

  task automatic test_single_byte;
    int base = vld_dat.size();
    int fb = ferr_cnt;
    send_frame(8'hA5, 1'b1, CPB);
    wait_clks(20);
    checks++; if (vld_dat.size() !== base + 1) begin errors++; $display("FAIL single_count got %0d want %0d", vld_dat.size(), base + 1); end
    checks++; if (last_dat !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", last_dat); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data_held got %h want a5", rx_data); end
    checks++; if (ferr_cnt !== fb) begin errors++; $display("FAIL single_ferr got %0d want %0d", ferr_cnt, fb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
  endtask

  task automatic test_frame_error;
    int base = vld_dat.size();
    int fb = ferr_cnt;
    send_frame(8'h81, 1'b0, CPB);
    wait_clks(40);
    checks++; if (ferr_cnt !== fb + 1) begin errors++; $display("FAIL ferr_count got %0d want %0d", ferr_cnt, fb + 1); end
    checks++; if (vld_dat.size() !== base) begin errors++; $display("FAIL ferr_no_valid got %0d want %0d", vld_dat.size(), base); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept got %h want a5", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_no_retrigger got busy=%b want 0", busy); end
    send_bit(1'b1, 20);
    send_frame(8'h81, 1'b1, CPB);
    wait_clks(20);
    checks++; if (vld_dat.size() !== base + 1) begin errors++; $display("FAIL ferr_recover_count got %0d want %0d", vld_dat.size(), base + 1); end
    checks++; if (last_dat !== 8'h81) begin errors++; $display("FAIL ferr_recover_data got %h want 81", last_dat); end
    checks++; if (ferr_cnt !== fb + 1) begin errors++; $display("FAIL ferr_recover_ferr got %0d want %0d", ferr_cnt, fb + 1); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d [3];
    int base = vld_dat.size();
    int fb = ferr_cnt;
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h3C;
    for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b1, CPB);
    wait_clks(20);
    checks++; if (vld_dat.size() !== base + 3) begin errors++; $display("FAIL b2b_count got %0d want %0d", vld_dat.size(), base + 3); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (base + i >= vld_dat.size()) begin
        errors++; $display("FAIL b2b_data[%0d] got none want %h", i, exp_d[i]);
      end else if (vld_dat[base + i] !== exp_d[i]) begin
        errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, vld_dat[base + i], exp_d[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (base + i >= vld_cyc.size()) begin
        errors++; $display("FAIL b2b_spacing[%0d] got none want 160", i);
      end else if (vld_cyc[base + i] - vld_cyc[base + i - 1] !== 160) begin
        errors++; $display("FAIL b2b_spacing[%0d] got %0d want 160", i, vld_cyc[base + i] - vld_cyc[base + i - 1]);
      end
    end
    checks++; if (ferr_cnt !== fb) begin errors++; $display("FAIL b2b_ferr got %0d want %0d", ferr_cnt, fb); end
  endtask

  task automatic test_start_glitch;
    int base = vld_dat.size();
    int fb = ferr_cnt;
    send_bit(1'b0, 4);
    send_bit(1'b1, 30);
    checks++; if (vld_dat.size() !== base) begin errors++; $display("FAIL glitch_no_valid got %0d want %0d", vld_dat.size(), base); end
    checks++; if (ferr_cnt !== fb) begin errors++; $display("FAIL glitch_no_ferr got %0d want %0d", ferr_cnt, fb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy=%b want 0", busy); end
    send_frame(8'h55, 1'b1, CPB);
    wait_clks(20);
    checks++; if (vld_dat.size() !== base + 1) begin errors++; $display("FAIL glitch_after_count got %0d want %0d", vld_dat.size(), base + 1); end
    checks++; if (last_dat !== 8'h55) begin errors++; $display("FAIL glitch_after_data got %h want 55", last_dat); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d = 8'h5A;
    int base = vld_dat.size();
    int fb = ferr_cnt;
    send_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bit(d[i], CPB);
    send_bit(d[4], CPB / 2);
    rst = 1'b1;
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_rx_valid got %b want 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    rxd = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(200);
    checks++; if (vld_dat.size() !== base) begin errors++; $display("FAIL midrst_no_valid got %0d want %0d", vld_dat.size(), base); end
    checks++; if (ferr_cnt !== fb) begin errors++; $display("FAIL midrst_no_ferr got %0d want %0d", ferr_cnt, fb); end
    send_frame(8'h5A, 1'b1, CPB);
    wait_clks(20);
    checks++; if (vld_dat.size() !== base + 1) begin errors++; $display("FAIL midrst_after_count got %0d want %0d", vld_dat.size(), base + 1); end
    checks++; if (last_dat !== 8'h5A) begin errors++; $display("FAIL midrst_after_data got %h want 5a", last_dat); end
  endtask

  task automatic test_baud_tolerance;
    int rates [2];
    rates[0] = 15; rates[1] = 17;
    for (int r = 0; r < 2; r++) begin
      int base = vld_dat.size();
      int fb = ferr_cnt;
      send_frame(8'hC3, 1'b1, rates[r]);
      wait_clks(30);
      checks++; if (vld_dat.size() !== base + 1) begin errors++; $display("FAIL baud%0d_count got %0d want %0d", rates[r], vld_dat.size(), base + 1); end
      checks++; if (last_dat !== 8'hC3) begin errors++; $display("FAIL baud%0d_data got %h want c3", rates[r], last_dat); end
      checks++; if (ferr_cnt !== fb) begin errors++; $display("FAIL baud%0d_ferr got %0d want %0d", rates[r], ferr_cnt, fb); end
    end
  endtask

  task automatic test_pulse_shape;
    checks++; if (both_high !== 1'b0) begin errors++; $display("FAIL pulse_exclusive got overlap=%b want 0", both_high); end
    checks++; if (long_pulse !== 1'b0) begin errors++; $display("FAIL pulse_width got long=%b want 0", long_pulse); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_frame_error();
    test_back_to_back();
    test_start_glitch();
    test_reset_mid_frame();
    test_baud_tolerance();
    test_pulse_shape();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive-side counterpart of the team's UART transmitter.
- Deserialises the asynchronous serial line `rxd` into bytes, LSB first.
- Timing uses a free clock-cycle counter; each bit is sampled at its mid-point.
- Each byte is presented to the system side as `rx_data` plus a one-cycle `rx_valid` strobe. Stop-bit failures are reported on `frame_err`.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); legal minimum 4.
- HALF_BIT, CLKS_PER_BIT/2 (2604), cycles from the detected start edge to the mid-start-bit sample.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  serial input, asynchronous to clk; idle high.
- rx_data  out  8  last correctly framed byte; bit 0 is the first data bit received.
- rx_valid  out  1  one-cycle pulse; rx_data is new in the same cycle.
- frame_err  out  1  one-cycle pulse when the stop bit samples 0.
- busy  out  1  high in every state except IDLE.

Behaviour:
- **Reset values:** rx_data=8'h00, rx_valid=0, frame_err=0, busy=0. State=IDLE, counters=0, shift register=0, both sync flops=1.
- **Reset mid-frame:** the frame is aborted, no pulse is emitted, and the state returns to IDLE.
- **Synchroniser:** rxd passes through 2 flops to give rxd_s. A third flop holds rxd_s_d. A start edge is rxd_s_d==1 && rxd_s==0.
- **IDLE:**
  - On a start edge: go to START, clear cnt.
  - A low level without a preceding high never starts a frame, so a stuck-low line is ignored.
- **START:**
  - cnt increments each clk.
  - At cnt==HALF_BIT-1, sample rxd_s:
    - 0: go to DATA, clear cnt, clear bit_idx.
    - 1: glitch rejected; return to IDLE with no output.
- **DATA:**
  - cnt counts 0..CLKS_PER_BIT-1, then wraps to 0. Each wrap is a mid-bit sample point.
  - At each sample point: shift register <= {rxd_s, shift[7:1]}, then bit_idx++.
  - After the sample with bit_idx==7: go to STOP, clear cnt.
- **STOP:**
  - At cnt==CLKS_PER_BIT-1, sample rxd_s.
  - If 1: rx_data <= shift register and rx_valid=1 on the next cycle only.
  - If 0: frame_err=1 on the next cycle only; rx_data keeps its old value.
  - In both cases go to IDLE.
- **Re-arm after framing error:** IDLE needs a fresh high-to-low edge, so a line held low after a framing error does not re-trigger.
- **Latency:** rx_valid rises exactly 1 clk after the stop-bit sample edge. Relative to the rxd falling edge at the pin, the stop-bit sample falls at 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT clocks, ±1 for edge alignment.
- **Back-to-back frames:**
  - The next start bit may begin immediately after the stop bit's nominal end.
  - The receiver is back in IDLE about half a bit before that point.
- **Exclusivity:** rx_valid and frame_err are never high together. Neither pulse lasts more than 1 cycle.
- **Widths:** cnt is 16 bits unsigned; bit_idx is 3 bits. No overflow is possible within legal parameters.
- **No flow control:** rx_data is held until the next good frame. The consumer must take it on the rx_valid cycle; an unread byte is overwritten.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=8 for simulation):
1. **Single byte:** drive frame 8'hA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 16 clk/bit → one rx_valid pulse, rx_data=8'hA5, frame_err never high, busy low again afterwards.
2. **Back-to-back:** bytes 8'h00, 8'hFF, 8'h3C sent with no idle gap → three rx_valid pulses in order with matching rx_data, spaced 160 clk apart.
3. **Start glitch:** rxd low for 4 clk, then high → stays in IDLE, no rx_valid, no frame_err. A valid 8'h55 frame sent afterwards is received correctly.
4. **Framing error:** frame 8'h81 with stop bit driven 0, line then held low for 40 clk → one frame_err pulse, no rx_valid, rx_data keeps the prior 8'hA5, no re-trigger while low. After the line goes high, 8'h81 is received correctly.
5. **Reset mid-frame:** assert rst during data bit 4 of 8'h5A → outputs return to reset values immediately, no pulse. A subsequent 8'h5A frame is received correctly.
6. **Baud tolerance:** transmit 8'hC3 at 15 clk/bit and again at 17 clk/bit (±6%) → both received as 8'hC3 with no frame_err.
